// File: rtl/alu_issue_ctrl.sv
// Issue stage for the external 2-bit-opcode registered ALU: register file, instruction
// handshake, operand drive and writeback. One instruction in flight, three cycles each.
module alu_issue_ctrl #(
    parameter int WIDTH = 32,
    parameter int NREGS = 8,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [1:0]       instr_op,
    input  logic [AW-1:0]    instr_rd,
    input  logic [AW-1:0]    instr_rs1,
    input  logic [AW-1:0]    instr_rs2,
    input  logic             wr_en,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             res_valid,
    output logic [AW-1:0]    res_rd,
    output logic [WIDTH-1:0] res_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   rf_q [NREGS];
    logic [WIDTH-1:0]   alu_a_q, alu_b_q, res_data_q;
    logic [1:0]         alu_op_q;
    logic [AW-1:0]      rd_q, res_rd_q;
    logic               res_valid_q;
    logic               accept;
    logic               ext_wr;

    assign accept = (state_q == S_IDLE) && instr_valid;
    // External writes are blocked only in WAIT, the sole cycle that owns the write port.
    assign ext_wr = wr_en && (state_q != S_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (instr_valid) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= 2'b00;
            rd_q        <= '0;
            res_valid_q <= 1'b0;
            res_rd_q    <= '0;
            res_data_q  <= '0;
        end else begin
            res_valid_q <= 1'b0;
            if (accept) begin
                alu_a_q  <= rf_q[instr_rs1];
                alu_b_q  <= rf_q[instr_rs2];
                alu_op_q <= instr_op;
                rd_q     <= instr_rd;
            end
            if (ext_wr) begin
                rf_q[wr_addr] <= wr_data;
            end
            if (state_q == S_WAIT) begin
                rf_q[rd_q]  <= alu_result;
                res_valid_q <= 1'b1;
                res_rd_q    <= rd_q;
                res_data_q  <= alu_result;
            end
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign wr_ready    = (state_q != S_WAIT);
    assign rd_data     = rf_q[rd_addr];
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign res_valid   = res_valid_q;
    assign res_rd      = res_rd_q;
    assign res_data    = res_data_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural registered ALU and a writeback scoreboard.
module tb_alu_issue_ctrl;

    localparam int W  = 32;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          instr_valid;
    logic          instr_ready;
    logic [1:0]    instr_op;
    logic [AW-1:0] instr_rd, instr_rs1, instr_rs2;
    logic          wr_en;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic [W-1:0]  alu_a, alu_b;
    logic [1:0]    alu_op;
    logic [W-1:0]  alu_result;
    logic          res_valid;
    logic [AW-1:0] res_rd;
    logic [W-1:0]  res_data;

    typedef struct {
        logic [AW-1:0] rd;
        logic [W-1:0]  data;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] model_rf [8];
    int           vectors = 0;
    int           miscompares = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(W), .NREGS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data)
    );

    function automatic logic [W-1:0] alu_fn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return (b >= 32) ? '0 : (a << b[4:0]);
            default: return (b >= 32) ? '0 : (a >> b[4:0]);
        endcase
    endfunction

    // External ALU: registered, no reset.
    always @(posedge clk) alu_result <= alu_fn(alu_op, alu_a, alu_b);

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && res_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_res_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("res_rd", {29'd0, res_rd}, {29'd0, e.rd});
                check("res_data", res_data, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rf(input string tag, input int a, input logic [W-1:0] exp);
        rd_addr = a[AW-1:0];
        #1;
        check(tag, rd_data, exp);
    endtask

    task automatic wr_reg(input int a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = d;
        tick();
        wr_en = 1'b0;
        model_rf[a] = d;
    endtask

    task automatic do_accept(input logic [1:0] op, input int rd, input int rs1, input int rs2, input bit push);
        exp_t e;
        bit   acc;
        instr_op = op; instr_rd = rd[AW-1:0]; instr_rs1 = rs1[AW-1:0]; instr_rs2 = rs2[AW-1:0];
        instr_valid = 1'b1;
        if (push) begin
            e.rd = rd[AW-1:0];
            e.data = alu_fn(op, model_rf[rs1], model_rf[rs2]);
            sb_q.push_back(e);
            model_rf[rd] = e.data;
        end
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            acc = instr_ready;
            tick();
        end
        instr_valid = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (instr_ready !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        if (n >= 10) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int acc_cyc[2];
        int nacc, lowcnt, cyc;
        bit acc;

        rst_n = 1'b0; instr_valid = 1'b0; instr_op = 2'b00;
        instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        for (int i = 0; i < 8; i++) model_rf[i] = '0;
        #12;
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_op", {30'd0, alu_op}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_instr_ready", {31'd0, instr_ready}, 32'd1);

        // Reset asserted while an instruction sits in WAIT: aborted, no writeback.
        wr_reg(1, 32'd9);
        do_accept(2'b00, 2, 1, 1, 1'b0);
        tick();
        check("abort_in_wait_wr_ready", {31'd0, wr_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_res_valid", {31'd0, res_valid}, 32'd0);
        for (int i = 0; i < 8; i++) chk_rf("abort_rf_zero", i, 32'd0);
        for (int i = 0; i < 8; i++) model_rf[i] = '0;
        #3;
        rst_n = 1'b1;
        tick();
        check("abort_instr_ready", {31'd0, instr_ready}, 32'd1);
        repeat (4) tick();
        chk_rf("abort_r2_zero", 2, 32'd0);

        // Add.
        wr_reg(1, 32'd5);
        wr_reg(2, 32'd7);
        do_accept(2'b00, 3, 1, 2, 1'b1);
        wait_idle();
        chk_rf("add_r3", 3, 32'd12);

        // Subtract with wrap.
        wr_reg(1, 32'd3);
        wr_reg(2, 32'd5);
        do_accept(2'b01, 4, 1, 2, 1'b1);
        wait_idle();
        chk_rf("sub_wrap_r4", 4, 32'hFFFF_FFFE);

        // Shifts, including an amount equal to the width.
        wr_reg(1, 32'd1);
        wr_reg(2, 32'd31);
        do_accept(2'b10, 6, 1, 2, 1'b1);
        wait_idle();
        chk_rf("shl31_r6", 6, 32'h8000_0000);
        wr_reg(2, 32'd32);
        do_accept(2'b10, 6, 1, 2, 1'b1);
        wait_idle();
        chk_rf("shl32_r6", 6, 32'd0);
        wr_reg(1, 32'h8000_0000);
        wr_reg(2, 32'd31);
        do_accept(2'b11, 7, 1, 2, 1'b1);
        wait_idle();
        chk_rf("shr31_r7", 7, 32'd1);

        // Same-edge external write and accept: operand is the pre-edge value.
        wr_reg(1, 32'd100);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'd200;
        do_accept(2'b00, 0, 1, 1, 1'b1);
        wr_en = 1'b0;
        model_rf[1] = 32'd200;
        wait_idle();
        chk_rf("same_edge_r0", 0, 32'd200);
        chk_rf("same_edge_r1", 1, 32'd200);

        // Back-to-back with instr_valid held; second uses the first's result.
        wr_reg(1, 32'd5);
        wr_reg(2, 32'd7);
        begin
            exp_t e;
            instr_op = 2'b00; instr_rd = 3'd3; instr_rs1 = 3'd1; instr_rs2 = 3'd2;
            instr_valid = 1'b1;
            e.rd = 3'd3; e.data = model_rf[1] + model_rf[2];
            sb_q.push_back(e); model_rf[3] = e.data;
            nacc = 0; lowcnt = 0; cyc = 0;
            for (int i = 0; i < 20 && nacc < 2; i++) begin
                acc = instr_ready;
                if (nacc == 1 && !instr_ready) lowcnt++;
                tick();
                cyc++;
                if (acc) begin
                    acc_cyc[nacc] = cyc;
                    nacc++;
                    if (nacc == 1) begin
                        instr_rd = 3'd5; instr_rs1 = 3'd3; instr_rs2 = 3'd3;
                        e.rd = 3'd5; e.data = model_rf[3] + model_rf[3];
                        sb_q.push_back(e); model_rf[5] = e.data;
                    end
                end
            end
            instr_valid = 1'b0;
            check("b2b_accepts", nacc, 32'd2);
            if (nacc == 2) check("b2b_spacing", acc_cyc[1] - acc_cyc[0], 32'd3);
            check("b2b_ready_low", lowcnt, 32'd2);
        end
        wait_idle();
        chk_rf("b2b_r5", 5, 32'd24);

        // External write to r3 held across the WAIT of an instruction targeting r3.
        do_accept(2'b00, 3, 1, 2, 1'b1);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'hDEAD_BEEF;
        tick();
        check("hold_wr_ready_wait", {31'd0, wr_ready}, 32'd0);
        tick();
        check("hold_wr_ready_idle", {31'd0, wr_ready}, 32'd1);
        chk_rf("hold_writeback_r3", 3, 32'd12);
        tick();
        wr_en = 1'b0;
        model_rf[3] = 32'hDEAD_BEEF;
        chk_rf("hold_ext_r3", 3, 32'hDEAD_BEEF);

        repeat (4) tick();
        check("scoreboard_drained", sb_q.size(), 32'd0);
        for (int i = 0; i < 8; i++) chk_rf("final_rf", i, model_rf[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
